// File: rtl/uart_xcvr_if.sv
// Client-side word bus of uart_xcvr: TX valid/ready/done handshake and RX result with error flags.
// The master is the byte-stream client; the slave is the transceiver.
interface uart_xcvr_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx_done;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_done, rx_valid, rx_data, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_done, rx_valid, rx_data, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_xcvr.sv
// Full-duplex UART: independent TX/RX FSMs. TX starts the cycle after handshake, no queue (tx_ready only when idle);
// RX samples bit centres via a 2-flop synchroniser and pulses rx_valid at mid-stop, with no backpressure.
module uart_xcvr #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_xcvr_if.slave bus,
  output logic       tx_out,
  input  logic       rx_in
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  tx_state_t            tx_state;
  logic [BW-1:0]        tx_baud;
  logic [CW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic                 tx_done_r;

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign bus.tx_done  = tx_done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_baud   <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_done_r <= 1'b0;
      tx_out    <= 1'b1;
    end else begin
      tx_done_r <= 1'b0;
      if (tx_state != TX_IDLE)
        tx_baud <= (tx_baud == BAUD_LAST) ? '0 : tx_baud + BW'(1);
      case (tx_state)
        TX_IDLE: if (bus.tx_valid) begin
          tx_shift <= bus.tx_data;
          tx_par   <= (^bus.tx_data) ^ ODD;
          tx_out   <= 1'b0;
          tx_baud  <= '0;
          tx_state <= TX_START;
        end
        TX_START: if (tx_baud == BAUD_LAST) begin
          tx_out   <= tx_shift[0];
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_baud == BAUD_LAST) begin
          if (tx_bit == DATA_LAST) begin
            tx_bit <= '0;
            if (PARITY_EN != 0) begin
              tx_out   <= tx_par;
              tx_state <= TX_PARITY;
            end else begin
              tx_out   <= 1'b1;
              tx_state <= TX_STOP;
            end
          end else begin
            tx_shift <= tx_shift >> 1;
            tx_out   <= tx_shift[1];
            tx_bit   <= tx_bit + CW'(1);
          end
        end
        TX_PARITY: if (tx_baud == BAUD_LAST) begin
          tx_out   <= 1'b1;
          tx_bit   <= '0;
          tx_state <= TX_STOP;
        end
        TX_STOP: begin
          // Raise done one cycle early so the registered pulse lands in the final stop cycle.
          if (tx_bit == STOP_LAST && tx_baud == BAUD_PRE)
            tx_done_r <= 1'b1;
          if (tx_baud == BAUD_LAST) begin
            if (tx_bit == STOP_LAST) begin
              tx_bit   <= '0;
              tx_state <= TX_IDLE;
            end else begin
              tx_bit <= tx_bit + CW'(1);
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  logic                 rx_meta, rx_sync, rx_armed, rx_perr;
  rx_state_t            rx_state;
  logic [BW-1:0]        rx_baud;
  logic [CW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state          <= RX_IDLE;
      rx_baud           <= '0;
      rx_bit            <= '0;
      rx_shift          <= '0;
      rx_perr           <= 1'b0;
      rx_armed          <= 1'b0;
      bus.rx_valid      <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      case (rx_state)
        // A falling edge only counts once the line has been seen high (recovers from a break).
        RX_IDLE: if (rx_sync) begin
          rx_armed <= 1'b1;
        end else if (rx_armed) begin
          rx_baud  <= '0;
          rx_state <= RX_START;
        end
        RX_START: if (rx_baud == BAUD_HALF) begin
          rx_baud  <= '0;
          rx_bit   <= '0;
          rx_perr  <= 1'b0;
          rx_state <= rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud <= rx_baud + BW'(1);
        end
        RX_DATA: if (rx_baud == BAUD_LAST) begin
          rx_baud  <= '0;
          rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == DATA_LAST) rx_state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          else                     rx_bit   <= rx_bit + CW'(1);
        end else begin
          rx_baud <= rx_baud + BW'(1);
        end
        RX_PARITY: if (rx_baud == BAUD_LAST) begin
          rx_baud  <= '0;
          rx_perr  <= rx_sync ^ (^rx_shift) ^ ODD;
          rx_state <= RX_STOP;
        end else begin
          rx_baud <= rx_baud + BW'(1);
        end
        RX_STOP: if (rx_baud == BAUD_LAST) begin
          rx_baud           <= '0;
          bus.rx_data       <= rx_shift;
          bus.rx_parity_err <= rx_perr;
          bus.rx_frame_err  <= ~rx_sync;
          bus.rx_valid      <= 1'b1;
          rx_armed          <= rx_sync;
          rx_state          <= RX_IDLE;
        end else begin
          rx_baud <= rx_baud + BW'(1);
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: 8N1 TX/RX, 8E1 loopback, 7O1 parity errors, 8N2 busy length, async reset.
module tb_uart_xcvr;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic rx0 = 1'b1, rx2 = 1'b1, rx3 = 1'b1;
  logic tx0, tx1, tx2, tx3;
  logic [15:0] q0[$], q1[$], q2[$];

  uart_xcvr_if #(.DATA_BITS(8)) b0();
  uart_xcvr_if #(.DATA_BITS(8)) b1();
  uart_xcvr_if #(.DATA_BITS(7)) b2();
  uart_xcvr_if #(.DATA_BITS(8)) b3();

  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .tx_out(tx0), .rx_in(rx0));
  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .tx_out(tx1), .rx_in(tx1));
  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .tx_out(tx2), .rx_in(rx2));
  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(b3), .tx_out(tx3), .rx_in(rx3));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input logic fe, input logic pe, input logic [8:0] d);
    return {5'd0, fe, pe, d};
  endfunction

  task automatic drive_bit(input int ln, input logic v);
    if (ln == 0) rx0 = v;
    else         rx2 = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int ln, input logic [8:0] d, input int nb, input bit par_en,
                            input bit odd, input bit flip, input logic stop_v);
    logic p;
    p = odd;
    drive_bit(ln, 1'b0);
    for (int i = 0; i < nb; i++) begin
      drive_bit(ln, d[i]);
      p = p ^ d[i];
    end
    if (par_en) drive_bit(ln, p ^ flip);
    drive_bit(ln, stop_v);
    drive_bit(ln, 1'b1);
  endtask

  // Scoreboard monitors: every rx_valid pops one expected {frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (rst_n && b0.rx_valid) begin
      if (q0.size() == 0) check("rx0_spurious", 16'(b0.rx_valid), 16'd0);
      else check("rx0_word", pk(b0.rx_frame_err, b0.rx_parity_err, 9'(b0.rx_data)), q0.pop_front());
    end
    if (rst_n && b1.rx_valid) begin
      if (q1.size() == 0) check("rx1_spurious", 16'(b1.rx_valid), 16'd0);
      else check("rx1_word", pk(b1.rx_frame_err, b1.rx_parity_err, 9'(b1.rx_data)), q1.pop_front());
    end
    if (rst_n && b2.rx_valid) begin
      if (q2.size() == 0) check("rx2_spurious", 16'(b2.rx_valid), 16'd0);
      else check("rx2_word", pk(b2.rx_frame_err, b2.rx_parity_err, 9'(b2.rx_data)), q2.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0]  fb;
    logic [31:0] cap;
    logic [7:0]  words [4];
    int k, budget, low;
    words = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    b0.tx_valid = 1'b0; b0.tx_data = '0;
    b1.tx_valid = 1'b0; b1.tx_data = '0;
    b2.tx_valid = 1'b0; b2.tx_data = '0;
    b3.tx_valid = 1'b0; b3.tx_data = '0;

    repeat (3) @(negedge clk);
    check("rst_tx_out",   16'(tx0), 16'd1);
    check("rst_tx_ready", 16'(b0.tx_ready), 16'd1);
    check("rst_tx_done",  16'(b0.tx_done), 16'd0);
    check("rst_rx_valid", 16'(b0.rx_valid), 16'd0);
    check("rst_rx_data",  16'(b0.rx_data), 16'd0);
    check("rst_rx_errs",  16'({b0.rx_frame_err, b0.rx_parity_err}), 16'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 TX of A5: start, LSB-first data, stop; done in cycle 40 after handshake.
    fb = {1'b1, 8'hA5, 1'b0};
    b0.tx_valid = 1'b1; b0.tx_data = 8'hA5;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      b0.tx_valid = 1'b0;
      check("tx_a5_bit",   16'(tx0), 16'(fb[i / CPB]));
      check("tx_a5_done",  16'(b0.tx_done), 16'(i == 39));
      check("tx_a5_ready", 16'(b0.tx_ready), 16'd0);
    end
    @(negedge clk);
    check("tx_a5_idle_ready", 16'(b0.tx_ready), 16'd1);
    check("tx_a5_idle_done",  16'(b0.tx_done), 16'd0);

    // 8N1 RX: clean frame, low stop bit, break, recovery frame, then idle-line glitch.
    q0.push_back(pk(1'b0, 1'b0, 9'h3C)); send_frame(0, 9'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    q0.push_back(pk(1'b1, 1'b0, 9'h81)); send_frame(0, 9'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    q0.push_back(pk(1'b1, 1'b0, 9'h00));
    rx0 = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx0 = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    q0.push_back(pk(1'b0, 1'b0, 9'h5A)); send_frame(0, 9'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    rx0 = 1'b0;
    @(negedge clk);
    rx0 = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("rx0_drained", 16'(q0.size()), 16'd0);

    // 7O1 RX: good, corrupted parity (data still delivered), good.
    q2.push_back(pk(1'b0, 1'b0, 9'h35)); send_frame(1, 9'h35, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    q2.push_back(pk(1'b0, 1'b1, 9'h35)); send_frame(1, 9'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    q2.push_back(pk(1'b0, 1'b0, 9'h7F)); send_frame(1, 9'h7F, 7, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rx2_drained", 16'(q2.size()), 16'd0);

    // 8E1 loopback: each word issued as soon as TX returns to idle.
    k = 0; budget = 0;
    while (k < 4 && budget < 400) begin
      @(negedge clk);
      budget++;
      if (b1.tx_ready) begin
        b1.tx_valid = 1'b1;
        b1.tx_data  = words[k];
        q1.push_back(pk(1'b0, 1'b0, 9'(words[k])));
        k++;
      end
    end
    @(negedge clk);
    b1.tx_valid = 1'b0;
    check("lb_issued", 16'(k), 16'd4);
    budget = 0;
    while (q1.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("lb_drained", 16'(q1.size()), 16'd0);

    // 8N2 TX: busy for 44 cycles, new tx_data while busy must not leak into the frame.
    b3.tx_valid = 1'b1; b3.tx_data = 8'h96;
    @(negedge clk);
    b3.tx_data = 8'h11;
    low = 0; cap = '0;
    while (b3.tx_ready == 1'b0 && low < 100) begin
      if (low % CPB == 1) cap[low / CPB] = tx3;
      low++;
      @(negedge clk);
    end
    b3.tx_valid = 1'b0;
    check("n2_busy_cycles", 16'(low), 16'd44);
    check("n2_frame", 16'(cap[10:0]), 16'({2'b11, 8'h96, 1'b0}));

    // Reset while TX is mid-data and RX is mid-data: immediate idle, no rx_valid afterwards.
    @(negedge clk);
    b0.tx_valid = 1'b1; b0.tx_data = 8'h00; rx0 = 1'b0;
    @(negedge clk);
    b0.tx_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_rst_tx_low", 16'(tx0), 16'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_out",   16'(tx0), 16'd1);
    check("mid_rst_tx_ready", 16'(b0.tx_ready), 16'd1);
    check("mid_rst_rx_valid", 16'(b0.rx_valid), 16'd0);
    @(negedge clk);
    rx0 = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30 * CPB) @(negedge clk);
    check("post_rst_rx_data", 16'(b0.rx_data), 16'd0);
    check("post_rst_tx_out",  16'(tx0), 16'd1);
    check("post_rst_q0",      16'(q0.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
